// File: rtl/setting_ctrl.sv
// Setting-path front end: synchronizes and debounces the mode/position/up buttons,
// then steps the setting mode and field position and issues field increment pulses.
//
// state (setting_mode) | meaning
// MODE_CLOCK           | normal timekeeping; position and up events ignored
// MODE_SETUP           | editing time; position cycles SEC->MIN->HOUR, up increments
// MODE_ALARM           | editing alarm; same field handling as SETUP
module setting_ctrl #(
  parameter int DEBOUNCE_CNT = 500000,
  parameter int CNT_W        = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sw_mode,
  input  logic       i_sw_position,
  input  logic       i_sw_up,
  output logic [1:0] setting_mode,
  output logic [1:0] setting_position,
  output logic       o_inc_pulse
);

  typedef enum logic [1:0] {
    MODE_CLOCK = 2'd0,
    MODE_SETUP = 2'd1,
    MODE_ALARM = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    POS_SEC  = 2'd0,
    POS_MIN  = 2'd1,
    POS_HOUR = 2'd2
  } pos_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  // bit 0 = mode, bit 1 = position, bit 2 = up
  logic [2:0]       raw;
  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [2:0]       deb;
  logic [2:0]       deb_q;
  logic [2:0]       ev;
  logic [CNT_W-1:0] cnt [3];

  mode_t mode_q, mode_d;
  pos_t  pos_q, pos_d;
  logic  inc_q, inc_d;

  assign raw = {i_sw_up, i_sw_position, i_sw_mode};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      ev    <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      // event is registered so it lines up one cycle after the debounced edge
      ev    <= deb & ~deb_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i] <= '0;
          deb[i] <= ~deb[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_CLOCK;
      pos_q  <= POS_SEC;
      inc_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      pos_q  <= pos_d;
      inc_q  <= inc_d;
    end
  end

  // one event per cycle: mode beats position beats up, losers are dropped
  always_comb begin
    mode_d = mode_q;
    pos_d  = pos_q;
    inc_d  = 1'b0;
    if (ev[0]) begin
      pos_d = POS_SEC;
      case (mode_q)
        MODE_CLOCK: mode_d = MODE_SETUP;
        MODE_SETUP: mode_d = MODE_ALARM;
        default:    mode_d = MODE_CLOCK;
      endcase
    end else if (ev[1]) begin
      if (mode_q != MODE_CLOCK) begin
        case (pos_q)
          POS_SEC: pos_d = POS_MIN;
          POS_MIN: pos_d = POS_HOUR;
          default: pos_d = POS_SEC;
        endcase
      end
    end else if (ev[2]) begin
      inc_d = (mode_q != MODE_CLOCK);
    end
  end

  assign setting_mode     = mode_q;
  assign setting_position = pos_q;
  assign o_inc_pulse      = inc_q;

endmodule
